// File: rtl/seq_div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package seq_div_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned VW = 4;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle between a controller and seq_divider.
interface seq_divider_if;
    import seq_div_pkg::*;

    logic          start;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          busy;
    logic          done;
    logic          dz;

    modport master (
        output start, a, b,
        input  q, r, busy, done, dz
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, dz
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import seq_div_pkg::*;
(
    input  logic [VW:0]   rin,
    input  logic          din,
    input  logic [VW-1:0] d,
    output logic [VW:0]   rout,
    output logic          qb
);

    logic [VW:0] rs;

    // rin is always below the divisor, so its top bit drops out of the shift.
    always_comb begin
        rs   = (VW+1)'({rin, din});
        qb   = (rs >= {1'b0, d});
        rout = qb ? (rs - {1'b0, d}) : rs;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Optional DIV_BY_ZERO_DETECT_EN: b==0 short-circuits to q=all-ones, r=0, dz=1.
module seq_divider
    import seq_div_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);

`ifdef DIV_BY_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW:0]   rem;
    logic [DW-1:0] qsr;
    logic [DW-1:0] q_q;
    logic [VW-1:0] r_q;
    logic          busy_q;
    logic          done_q;
    logic          dz_q;

    logic [VW:0]   rem_nxt;
    logic          qbit;
    logic          zero_div;

    div_step u_step (
        .rin  (rem),
        .din  (dvd[DW-1]),
        .d    (dvs),
        .rout (rem_nxt),
        .qb   (qbit)
    );

    assign zero_div = DZ_EN && (bus.b == '0);

    // Control and datapath registers; start is honoured only outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            qsr    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvd  <= bus.a;
                        dvs  <= bus.b;
                        rem  <= '0;
                        qsr  <= '0;
                        cnt  <= CW'(DW - 1);
                        dz_q <= zero_div;
                        if (zero_div) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            q_q    <= '1;
                            r_q    <= '0;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end else begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    qsr <= {qsr[DW-2:0], qbit};
                    dvd <= dvd << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        q_q    <= {qsr[DW-2:0], qbit};
                        r_q    <= rem_nxt[VW-1:0];
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz   = dz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider: the inverse of the team's 4x4 array multiplier.
- Takes an 8-bit dividend (a multiplier product width) and a 4-bit divisor.
- Produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Used in the lab datapath wherever a product must be split back into factors.
- Start/done handshake to a controlling FSM.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width.
- CW, 3, step counter width; equals clog2(DW).

Ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on the rising edge of clk.
- a  input  DW  dividend; sampled only when start is accepted.
- b  input  VW  divisor; sampled only when start is accepted.
- q  output  DW  quotient, registered.
- r  output  VW  remainder, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when q and r become valid.
- dz  output  1  divide-by-zero flag; tied 0 unless DIV_BY_ZERO_DETECT_EN is defined.

Behaviour:
- Reset:
  - Synchronous and active-high, taking priority over everything else.
  - All registers go to 0: q=0, r=0, busy=0, done=0, dz=0, state=IDLE.
  - Reset asserted mid-division aborts the operation; no done pulse is produced.
- States:
  - IDLE: waiting for start.
  - RUN: DW cycles of computation.
  - DONE: one cycle, results presented.
- Start acceptance:
  - start is accepted in IDLE or DONE (back-to-back operations are allowed).
  - start is ignored in RUN.
- Edge E0 (start accepted):
  - Latch a into the dividend shift register and b into the divisor register.
  - Clear the 5-bit (VW+1) partial remainder R and the quotient shift register.
  - Set count=DW-1 and state=RUN; busy=1 from the next cycle.
- Each RUN edge (one restoring step):
  - R' = {R[VW-1:0], dividend MSB}, then shift the dividend left.
  - If R' >= {1'b0,b}: R = R' - b and the quotient bit is 1.
  - Otherwise: R = R' and the quotient bit is 0.
  - The quotient bit shifts into the quotient register LSB.
  - R never exceeds 5 bits, since R < b before the shift.
- End of RUN:
  - The edge with count==0 (edge E8) loads q and r=R[VW-1:0] and moves to DONE.
  - busy falls and done=1 for exactly one cycle.
- Latency: done is visible 8 cycles after the start-accept edge. Throughput is one division per 9 cycles.
- After DONE:
  - Without start, the next edge returns to IDLE and done=0.
  - q, r and dz hold until the next completion or reset.
  - q and r never change during RUN; they show the previous result.
- Simultaneous start and reset: reset wins.
- Inputs a and b may change freely after acceptance.

Optional Feature:
- Macro: DIV_BY_ZERO_DETECT_EN.
- Defined:
  - start with b==0 skips RUN and goes straight to DONE on the next edge (done one cycle after acceptance).
  - Result is q=8'hFF, r=0, dz=1.
  - dz is cleared at the next accepted start.
- Undefined:
  - b==0 runs the normal 8-step algorithm, giving q=8'hFF and r=a[3:0].
  - dz is constant 0.

Decomposition:
- Shared package seq_div_pkg:
  - State enum {IDLE, RUN, DONE}.
  - DW, VW and CW constants.
- Sub-module div_step:
  - Combinational single restoring step.
  - Inputs: R (VW+1 bits), incoming dividend bit, divisor.
  - Outputs: next R and the quotient bit.
  - Instantiated once in seq_divider.

Test Plan:
- a=200, b=7 -> done 8 cycles after accept; q=28, r=4, busy high for exactly 8 cycles.
- a=255,b=15 -> q=17,r=0; a=5,b=9 -> q=0,r=5; a=255,b=1 -> q=255,r=0; a=0,b=1 -> q=0,r=0.
- Pulse start again at cycle 3 of RUN with a=10,b=3 -> ignored; q=28,r=4 from the first op. Then start on the DONE cycle with a=10,b=3 -> accepted; q=3,r=1.
- Assert reset at cycle 4 of RUN -> next cycle q=0, r=0, busy=0, done=0, state IDLE; no done pulse follows.
- a=77,b=0 without the macro -> done after 8 cycles, q=8'hFF, r=13, dz=0. With the macro -> done one cycle after accept, q=8'hFF, r=0, dz=1; a following a=9,b=3 gives q=3, r=0, and dz is cleared.
- Exhaustive sweep of all 256x15 nonzero (a,b) pairs -> q*b+r==a and r<b for every pair.
